// File: rtl/inner_dot_result_collector_pkg.sv
// Shared constants and types for the inner-dot result collector.
// INT8 limits, default sum width, shift-field width, clamp kinds.
package inner_dot_result_collector_pkg;

  localparam int SUM_WIDTH_DEF = 20;
  localparam int SHIFT_W       = 4;
  localparam int INT8_MAX      = 127;
  localparam int INT8_MIN      = -128;

  typedef enum logic [1:0] {
    CLAMP_NONE,
    CLAMP_RELU,
    CLAMP_HI,
    CLAMP_LO
  } clamp_e;

endpackage

// File: rtl/inner_dot_result_collector_sync_fifo.sv
// Synchronous FIFO with registered storage and head output.
// Ports: push/din/full, pop/empty/dout, drop = push refused.
module inner_dot_result_collector_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout,
  output logic         drop
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign dout  = empty ? '0 : mem_q[rd_q];

  // A pop on a full FIFO frees the slot the push needs.
  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    drop    = push & full & ~do_pop;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + AW'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + AW'(1);
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + (AW+1)'(1);
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/inner_dot_result_collector.sv
// Collects MAC sums, requantizes to int8, buffers and streams them.
// Ports: acc_* in, out_* valid/ready stream, sat/drop stats, overflow.
module inner_dot_result_collector
  import inner_dot_result_collector_pkg::*;
#(
  parameter int SUM_WIDTH  = SUM_WIDTH_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        acc_done,
  input  logic signed [SUM_WIDTH-1:0] acc_sum,
  input  logic [SHIFT_W-1:0]          shift,
  input  logic                        relu_en,
  output logic                        out_valid,
  output logic [7:0]                  out_data,
  input  logic                        out_ready,
  input  logic                        clr_stats,
  output logic [CNT_WIDTH-1:0]        sat_cnt,
  output logic [CNT_WIDTH-1:0]        drop_cnt,
  output logic                        overflow
);

  localparam int XW = SUM_WIDTH + 1;
  localparam logic signed [XW-1:0] MAX_X = XW'(INT8_MAX);
  localparam logic signed [XW-1:0] MIN_X = XW'(INT8_MIN);

  logic signed [XW-1:0] ext;
  logic signed [XW-1:0] rnd;
  logic signed [XW-1:0] s1_val_d, s1_val_q;
  logic                 s1_relu_d, s1_relu_q;
  logic                 s1_valid_d, s1_valid_q;

  clamp_e     clamp;
  logic [7:0] res;
  logic       sat_ev;
  logic       fifo_full;
  logic       fifo_empty;
  logic       drop;

  logic [CNT_WIDTH-1:0] sat_cnt_d, sat_cnt_q;
  logic [CNT_WIDTH-1:0] drop_cnt_d, drop_cnt_q;
  logic                 ovf_d, ovf_q;

  // Stage 1: widened round-half-up then arithmetic shift.
  always_comb begin
    ext = {acc_sum[SUM_WIDTH-1], acc_sum};
    rnd = '0;
    if (shift != '0) begin
      rnd = XW'(1) << (shift - SHIFT_W'(1));
    end
    s1_val_d   = (ext + rnd) >>> shift;
    s1_relu_d  = relu_en;
    s1_valid_d = acc_done;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_val_q   <= '0;
      s1_relu_q  <= 1'b0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_val_q   <= s1_val_d;
      s1_relu_q  <= s1_relu_d;
      s1_valid_q <= s1_valid_d;
    end
  end

  // Stage 2: ReLU takes priority, so a clamped negative never
  // registers as a low saturation.
  always_comb begin
    clamp = CLAMP_NONE;
    unique case (1'b1)
      s1_relu_q && (s1_val_q < 0):   clamp = CLAMP_RELU;
      s1_val_q > MAX_X:              clamp = CLAMP_HI;
      !s1_relu_q && (s1_val_q < MIN_X): clamp = CLAMP_LO;
      default:                       clamp = CLAMP_NONE;
    endcase
    res = s1_val_q[7:0];
    case (clamp)
      CLAMP_RELU: res = 8'h00;
      CLAMP_HI:   res = 8'h7f;
      CLAMP_LO:   res = 8'h80;
      default:    res = s1_val_q[7:0];
    endcase
    sat_ev = s1_valid_q &
             ((clamp == CLAMP_HI) | (clamp == CLAMP_LO));
  end

  inner_dot_result_collector_sync_fifo #(
    .W     (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s1_valid_q),
    .din   (res),
    .pop   (out_ready),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (out_data),
    .drop  (drop)
  );

  assign out_valid = ~fifo_empty;

  // Counters stick at all-ones; clear beats any same-cycle event.
  always_comb begin
    sat_cnt_d  = sat_cnt_q;
    drop_cnt_d = drop_cnt_q;
    ovf_d      = ovf_q | drop;
    if (sat_ev && (sat_cnt_q != '1)) begin
      sat_cnt_d = sat_cnt_q + CNT_WIDTH'(1);
    end
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
    end
    if (clr_stats) begin
      sat_cnt_d  = '0;
      drop_cnt_d = '0;
      ovf_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_q  <= '0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      sat_cnt_q  <= sat_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign sat_cnt  = sat_cnt_q;
  assign drop_cnt = drop_cnt_q;
  assign overflow = ovf_q;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_inner_dot_result_collector.sv
// Bench for inner_dot_result_collector: directed cases plus random
// traffic against a queue-based reference model.
module tb_inner_dot_result_collector;

  localparam int DEPTH = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               acc_done;
  logic signed [19:0] acc_sum;
  logic [3:0]         shift;
  logic               relu_en;
  logic               out_valid;
  logic [7:0]         out_data;
  logic               out_ready;
  logic               clr_stats;
  logic [7:0]         sat_cnt;
  logic [7:0]         drop_cnt;
  logic               overflow;

  inner_dot_result_collector #(
    .SUM_WIDTH  (20),
    .FIFO_DEPTH (DEPTH),
    .CNT_WIDTH  (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .acc_done  (acc_done),
    .acc_sum   (acc_sum),
    .shift     (shift),
    .relu_en   (relu_en),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .clr_stats (clr_stats),
    .sat_cnt   (sat_cnt),
    .drop_cnt  (drop_cnt),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int q[$];
  bit pend_v;
  int pend_r;
  bit pend_s;
  int m_sat;
  int m_drop;
  bit m_ovf;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Real-number semantics: floor((sum + half) / 2^sh), then clamp.
  function automatic void requant(input int sum, input int sh,
                                  input bit relu, output int r,
                                  output bit sat);
    longint v;
    longint d;
    longint f;
    d = 1;
    repeat (sh) d = d * 2;
    v = longint'(sum) + ((sh > 0) ? d / 2 : 0);
    f = v / d;
    if ((v % d) != 0 && v < 0) f = f - 1;
    sat = 1'b0;
    if (relu && f < 0) r = 0;
    else if (f > 127) begin r = 127; sat = 1'b1; end
    else if (f < -128) begin r = -128; sat = 1'b1; end
    else r = int'(f);
  endfunction

  function automatic int head();
    return (q.size() > 0) ? q[0] : 0;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, int'(out_valid), int'(q.size() > 0));
    chk({tag, ".data"}, int'($signed(out_data)), head());
    chk({tag, ".sat"}, int'(sat_cnt), m_sat);
    chk({tag, ".drop"}, int'(drop_cnt), m_drop);
    chk({tag, ".ovf"}, int'(overflow), int'(m_ovf));
  endtask

  // Called at a negedge: drive, advance model one edge, check.
  task automatic step(input bit done, input int sum, input int sh,
                      input bit relu, input bit rdy, input bit clr,
                      input string tag);
    bit pop;
    bit drp;
    acc_done  = done;
    acc_sum   = 20'(sum);
    shift     = 4'(sh);
    relu_en   = relu;
    out_ready = rdy;
    clr_stats = clr;
    pop = (q.size() > 0) && rdy;
    drp = 1'b0;
    if (pop) void'(q.pop_front());
    if (pend_v) begin
      if (q.size() < DEPTH) q.push_back(pend_r);
      else drp = 1'b1;
    end
    if (clr) begin
      m_sat  = 0;
      m_drop = 0;
      m_ovf  = 1'b0;
    end else begin
      if (pend_v && pend_s && m_sat < 255) m_sat++;
      if (drp && m_drop < 255) m_drop++;
      if (drp) m_ovf = 1'b1;
    end
    pend_v = done;
    if (done) requant(sum, sh, relu, pend_r, pend_s);
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle(input bit rdy, input string tag);
    step(1'b0, 0, 0, 1'b0, rdy, 1'b0, tag);
  endtask

  task automatic model_reset();
    q.delete();
    pend_v = 1'b0;
    m_sat  = 0;
    m_drop = 0;
    m_ovf  = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    acc_done  = 1'b0;
    acc_sum   = '0;
    shift     = '0;
    relu_en   = 1'b0;
    out_ready = 1'b0;
    clr_stats = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // Basic rounding, with latency visible on valid.
    step(1, 384, 8, 0, 0, 0, "r384_e0");
    chk("lat_e0", int'(out_valid), 0);
    idle(0, "r384_e1");
    chk("r384_lit", int'($signed(out_data)), 2);
    idle(1, "pop1");
    step(1, -384, 8, 0, 1, 0, "rm384");
    idle(1, "rm384_w");
    chk("rm384_lit", int'($signed(out_data)), -1);
    idle(1, "pop2");

    // Saturation high and low.
    step(1, 40000, 8, 0, 1, 0, "s_hi");
    step(1, -40000, 8, 0, 1, 0, "s_lo");
    chk("s_hi_lit", int'($signed(out_data)), 127);
    idle(1, "s_lo_w");
    chk("s_lo_lit", int'($signed(out_data)), -128);
    chk("sat2_lit", int'(sat_cnt), 2);
    idle(1, "s_drain");

    // ReLU clamps are not saturations.
    step(1, -384, 8, 1, 1, 0, "relu1");
    step(1, -524288, 8, 1, 1, 0, "relu2");
    idle(1, "relu_w");
    chk("relu_sat_lit", int'(sat_cnt), 2);
    idle(1, "relu_d");

    // No shift.
    step(1, 5, 0, 0, 1, 0, "sh0_5");
    step(1, 200, 0, 0, 1, 0, "sh0_200");
    idle(1, "sh0_w");
    chk("sh0_sat_lit", int'(sat_cnt), 3);
    idle(1, "sh0_d");

    // Fill past depth with no ready: fifth result drops.
    for (int i = 1; i <= 5; i++) step(1, 256 * i, 8, 0, 0, 0, "fill");
    idle(0, "fill_drop");
    chk("drop_lit", int'(drop_cnt), 1);
    chk("ovf_lit", int'(overflow), 1);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_lit", int'($signed(out_data)), i);
      idle(1, "drain");
    end
    chk("drain_empty", int'(out_valid), 0);

    // Full with a same-edge pop: no drop.
    for (int i = 1; i <= 5; i++) step(1, 256 * i, 8, 0, 0, 0, "fill2");
    idle(1, "fill2_pp");
    chk("nodrop_lit", int'(drop_cnt), 1);
    repeat (5) idle(1, "drain2");

    // Clear coinciding with a saturation event.
    step(1, 40000, 8, 0, 1, 0, "clr_sat");
    step(0, 0, 0, 0, 1, 1, "clr_edge");
    chk("clr_lit", int'(sat_cnt), 0);
    idle(1, "clr_d");

    // Async reset with two results in flight.
    step(1, 384, 8, 0, 0, 0, "rst_a");
    step(1, 768, 8, 0, 0, 0, "rst_b");
    rst_n    = 1'b0;
    acc_done = 1'b0;
    #2;
    model_reset();
    check_all("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) idle(1, "rst_after");

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      int s;
      int sh;
      s  = int'($urandom_range(0, 1048575)) - 524288;
      if ($urandom_range(0, 3) == 0) s = s / 256;
      sh = int'($urandom_range(0, 15));
      step(($urandom_range(0, 9) < 6), s, sh,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) < 5,
           $urandom_range(0, 49) == 0, "rand");
    end
    repeat (DEPTH + 2) idle(1, "final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
